// File: rtl/csr_timer_bank_if.sv
// CSR instruction-access port between the CSR file and the timer bank.
// The CSR file drives the request side; the bank returns read data.
interface csr_timer_bank_if;
  logic        csr_we;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic [31:0] csr_rvalue;

  modport master (
    output csr_we,
    output csr_num,
    output csr_wmask,
    output csr_wvalue,
    input  csr_rvalue
  );

  modport slave (
    input  csr_we,
    input  csr_num,
    input  csr_wmask,
    input  csr_wvalue,
    output csr_rvalue
  );
endinterface

// File: rtl/csr_timer_bank.sv
// Bank of NUM_TIMERS prescaled down-counters mapped as TCFG/TVAL/TICLR/TPRE
// quadruples starting at BASE_NUM; pending bits drive timer_int.
module csr_timer_bank #(
  parameter int          NUM_TIMERS = 4,
  parameter int          CNT_W      = 32,
  parameter int          PRE_W      = 8,
  parameter logic [13:0] BASE_NUM   = 14'h41
) (
  input  logic                  clk,
  input  logic                  reset,
  csr_timer_bank_if.slave       csr,
  output logic [NUM_TIMERS-1:0] timer_int,
  output logic                  timer_int_any
);

  localparam logic [13:0] WIN = 14'(4 * NUM_TIMERS);

  logic [13:0] rel;
  logic        in_win;
  logic [1:0]  off;
  logic [31:0] wbits;
  logic [31:0] rd_ch [NUM_TIMERS];

  assign rel    = csr.csr_num - BASE_NUM;
  assign in_win = (csr.csr_num >= BASE_NUM) && (rel < WIN);
  assign off    = rel[1:0];
  assign wbits  = csr.csr_wmask & csr.csr_wvalue;

  for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_ch
    localparam logic [11:0] IDX = 12'(i);

    logic [31:0]      cfg_q;
    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pend_q;

    logic             hit;
    logic             wr_cfg;
    logic             wr_pre;
    logic             clr;
    logic             tick;
    logic             step;
    logic             wrap;
    logic [31:0]      cfg_new;
    logic [31:0]      pre_new;
    logic [CNT_W-1:0] load_v;
    logic [CNT_W-1:0] reload_v;
    logic [31:0]      rd;

    assign hit    = in_win && (rel[13:2] == IDX);
    assign wr_cfg = csr.csr_we && hit && (off == 2'd0);
    assign wr_pre = csr.csr_we && hit && (off == 2'd3);
    assign clr    = csr.csr_we && hit && (off == 2'd2) && wbits[0];

    assign cfg_new = wbits | (~csr.csr_wmask & cfg_q);
    assign pre_new = wbits | (~csr.csr_wmask & 32'(pre_q));

    assign load_v   = CNT_W'({cfg_new[31:2], 2'b00});
    assign reload_v = CNT_W'({cfg_q[31:2], 2'b00});

    // All-ones is the halted state of an expired one-shot
    assign tick = cfg_q[0] && (pc_q == pre_q);
    assign step = tick && (cnt_q != '1);
    assign wrap = step && (cnt_q == '0);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cfg_q  <= '0;
        pre_q  <= '0;
        pc_q   <= '0;
        cnt_q  <= '1;
        pend_q <= 1'b0;
      end else begin
        if (wr_cfg) cfg_q <= cfg_new;
        if (wr_pre) pre_q <= pre_new[PRE_W-1:0];
        if (wr_cfg && cfg_new[0]) begin
          cnt_q <= load_v;
          pc_q  <= '0;
        end else if (cfg_q[0]) begin
          pc_q <= tick ? '0 : pc_q + PRE_W'(1);
          if (step) begin
            if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
            else if (cfg_q[1]) cnt_q <= reload_v;
            else cnt_q <= '1;
          end
        end
        if (wrap) pend_q <= 1'b1;
        else if (clr) pend_q <= 1'b0;
      end
    end

    always_comb begin
      rd = '0;
      if (hit) begin
        unique case (off)
          2'd0: rd = cfg_q;
          2'd1: rd = 32'(cnt_q);
          2'd2: rd = '0;
          2'd3: rd = 32'(pre_q);
        endcase
      end
    end

    assign rd_ch[i]     = rd;
    assign timer_int[i] = pend_q;
  end

  always_comb begin
    csr.csr_rvalue = '0;
    for (int i = 0; i < NUM_TIMERS; i++)
      csr.csr_rvalue = csr.csr_rvalue | rd_ch[i];
  end

  assign timer_int_any = |timer_int;

endmodule
